// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory among NUM_CH requesters: round-robin grant,
// burst locking, host override on channel 0 and a tagged read-return pipeline.
module mem_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 8,
    parameter int NUM_CH    = 3,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               ext_en_i,
    input  logic [NUM_CH-1:0]                  req_i,
    input  logic [NUM_CH-1:0]                  wr_i,
    input  logic [NUM_CH-1:0]                  lock_i,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]      addr_i,
    input  logic [NUM_CH-1:0][LANES*WIDTH-1:0] wdata_i,
    output logic [NUM_CH-1:0]                  gnt_o,
    output logic [NUM_CH-1:0]                  rvalid_o,
    output logic [LANES*WIDTH-1:0]             rdata_o,
    output logic                               mem_cenb_o,
    output logic                               mem_wenb_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    output logic [LANES*WIDTH-1:0]             mem_d_o,
    input  logic [LANES*WIDTH-1:0]             mem_q_i,
    output logic                               busy_o
);
    localparam int DW = LANES * WIDTH;
    localparam int CW = $clog2(NUM_CH);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [CW-1:0]                 ptr_q, owner_q, excl_ch_q;
    logic                          lock_q, excl_q;
    logic [BW-1:0]                 cnt_q;
    logic [RD_LAT-1:0][NUM_CH-1:0] tag_q;
    logic [ADDR_W-1:0]             addr_hold_q;
    logic [DW-1:0]                 d_hold_q;

    logic [CW-1:0]     gnt_idx, ptr_nx;
    logic              gnt_any, lock_hit;
    logic [BW-1:0]     cnt_nx;
    logic [NUM_CH-1:0] rr_mask, others, gnt_vec;
    int                idx;

    always_comb begin
        // A channel that just hit the burst limit steps aside only if someone else wants the port.
        others            = req_i;
        others[excl_ch_q] = 1'b0;
        rr_mask           = (excl_q && |others) ? others : req_i;
        lock_hit          = lock_q && req_i[owner_q];
        gnt_any           = 1'b0;
        gnt_idx           = '0;
        idx               = 0;
        if (rstn_i) begin
            if (ext_en_i) begin
                gnt_any = req_i[0];
            end else if (lock_hit) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end else begin
                for (int off = 0; off < NUM_CH; off++) begin
                    idx = (int'(ptr_q) + off) % NUM_CH;
                    if (!gnt_any && rr_mask[CW'(idx)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = CW'(idx);
                    end
                end
            end
        end
        gnt_vec = '0;
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
        ptr_nx = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        cnt_nx = cnt_q + 1'b1;
    end

    assign gnt_o      = gnt_vec;
    assign mem_cenb_o = ~gnt_any;
    assign mem_wenb_o = gnt_any ? ~wr_i[gnt_idx] : 1'b1;
    assign mem_addr_o = !rstn_i ? '0 : (gnt_any ? addr_i[gnt_idx] : addr_hold_q);
    assign mem_d_o    = !rstn_i ? '0 : (gnt_any ? wdata_i[gnt_idx] : d_hold_q);
    assign rvalid_o   = rstn_i ? tag_q[RD_LAT-1] : '0;
    assign busy_o     = rstn_i && |tag_q;
    assign rdata_o    = (rstn_i && |tag_q[RD_LAT-1]) ? mem_q_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            excl_ch_q   <= '0;
            lock_q      <= 1'b0;
            excl_q      <= 1'b0;
            cnt_q       <= '0;
            tag_q       <= '0;
            addr_hold_q <= '0;
            d_hold_q    <= '0;
        end else begin
            excl_q   <= 1'b0;
            tag_q[0] <= gnt_vec & ~wr_i;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (gnt_any) begin
                addr_hold_q <= addr_i[gnt_idx];
                d_hold_q    <= wdata_i[gnt_idx];
            end
            if (ext_en_i) begin
                // Host override drops any burst; pointer is left where it was.
                lock_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                if (gnt_any) ptr_q <= ptr_nx;
                if (lock_hit) begin
                    if (int'(cnt_nx) >= MAX_BURST) begin
                        lock_q    <= 1'b0;
                        cnt_q     <= '0;
                        excl_q    <= 1'b1;
                        excl_ch_q <= owner_q;
                    end else if (!lock_i[owner_q]) begin
                        lock_q <= 1'b0;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_nx;
                    end
                end else if (gnt_any && lock_i[gnt_idx]) begin
                    owner_q <= gnt_idx;
                    if (MAX_BURST > 1) begin
                        lock_q <= 1'b1;
                        cnt_q  <= BW'(1);
                    end else begin
                        lock_q    <= 1'b0;
                        cnt_q     <= '0;
                        excl_q    <= 1'b1;
                        excl_ch_q <= gnt_idx;
                    end
                end else begin
                    lock_q <= 1'b0;
                    cnt_q  <= '0;
                end
            end
        end
    end
endmodule
